// File: rtl/jtag_debug_bridge_v2_if.sv
// Debug-bus connection between the bridge (master) and the memory-mapped debug fabric (slave).
interface jtag_debug_bridge_v2_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  dbg_req;
  logic                  dbg_wr;
  logic [ADDR_WIDTH-1:0] dbg_addr;
  logic [DATA_WIDTH-1:0] dbg_wr_val;
  logic [DATA_WIDTH-1:0] dbg_rd_val;
  logic                  dbg_ack;

  modport master (
    output dbg_req, dbg_wr, dbg_addr, dbg_wr_val,
    input  dbg_rd_val, dbg_ack
  );

  modport slave (
    input  dbg_req, dbg_wr, dbg_addr, dbg_wr_val,
    output dbg_rd_val, dbg_ack
  );
endinterface

// File: rtl/jtag_debug_bridge_v2.sv
// JTAG debug bridge: scan registers, CPU run control and debug-bus master, all in the clk domain.
module jtag_debug_bridge_v2 #(
  parameter int          DATA_WIDTH     = 16,
  parameter int          ADDR_WIDTH     = 16,
  parameter int          PROC_WIDTH     = 8,
  parameter logic [31:0] IDCODE         = 32'h53454c49,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            ir,
  input  logic                  tdi,
  output logic                  tdo,
  input  logic                  sdr,
  input  logic                  cdr,
  input  logic                  udr,
  input  logic                  debug_stopped,
  output logic                  debug_seize,
  output logic                  debug_reset,
  output logic                  debug_run,
  output logic [PROC_WIDTH-1:0] debug_proc,
  input  logic [DATA_WIDTH-1:0] debug_val,
  jtag_debug_bridge_v2_if.master dbg
);

  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] IR_IDCODE = 3'd0;
  localparam logic [2:0] IR_STATUS = 3'd1;
  localparam logic [2:0] IR_VALUE  = 3'd2;
  localparam logic [2:0] IR_RUN    = 3'd3;
  localparam logic [2:0] IR_ADDR   = 3'd4;

  typedef enum logic [1:0] {IDLE, BUS, RUN_START, RUN_STOP} state_e;

  state_e                  state_q, state_d;
  logic                    busy;
  logic                    bypass_q;
  logic [31:0]             idSr_q;
  logic [16:0]             statusSr_q;
  logic [DATA_WIDTH+1:0]   valueSr_q;
  logic [PROC_WIDTH-1:0]   procSr_q;
  logic [ADDR_WIDTH-1:0]   addrSr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   shadow_q;
  logic [DATA_WIDTH-1:0]   busWrVal_q;
  logic                    busWr_q;
  logic                    autoInc_q;
  logic                    overrun_q;
  logic                    timeout_q;
  logic                    debugSeize_q;
  logic                    debugReset_q;
  logic                    debugRun_q;
  logic [PROC_WIDTH-1:0]   debugProc_q;
  logic [CNT_W-1:0]        timeoutCnt_q;

  logic                    isIdle, updStrobe, statusWrite, clearErr;
  logic                    valueStart, runStart, addrLoad, overrunSet;
  logic                    timeoutHit, busDone, runDone, timeoutEvent;
  logic [16:0]             statusCapture;
  logic [DATA_WIDTH+1:0]   valueCapture;

  // Update only fires when neither capture nor shift claims the register this cycle.
  assign isIdle      = (state_q == IDLE);
  assign updStrobe   = udr & ~cdr & ~sdr;
  assign statusWrite = updStrobe & (ir == IR_STATUS) & statusSr_q[16];
  assign clearErr    = statusWrite & statusSr_q[2];
  assign valueStart  = updStrobe & (ir == IR_VALUE) &
                       (valueSr_q[DATA_WIDTH] | valueSr_q[DATA_WIDTH+1]);
  assign runStart    = updStrobe & (ir == IR_RUN);
  assign addrLoad    = updStrobe & (ir == IR_ADDR);
  assign overrunSet  = ~isIdle & (valueStart | runStart | addrLoad);

  // Completion wins over timeout when both land on the same cycle.
  assign timeoutHit   = (timeoutCnt_q == CNT_MAX);
  assign busDone      = (state_q == BUS) & dbg.dbg_ack;
  assign runDone      = (state_q == RUN_STOP) & debug_stopped;
  assign timeoutEvent = timeoutHit & (((state_q == BUS) & ~dbg.dbg_ack) |
                                      ((state_q == RUN_START) & debug_stopped) |
                                      ((state_q == RUN_STOP) & ~debug_stopped));

  assign statusCapture = {1'b0, 11'b0, overrun_q, timeout_q, busy, debugReset_q, ~debug_stopped};
  assign valueCapture  = {1'b0, ~busy, shadow_q};

  // Scan output: selected register LSB while shifting, bypass flop otherwise.
  always_comb begin
    tdo = bypass_q;
    if (sdr) begin
      case (ir)
        IR_IDCODE: tdo = idSr_q[0];
        IR_STATUS: tdo = statusSr_q[0];
        IR_VALUE:  tdo = valueSr_q[0];
        IR_RUN:    tdo = procSr_q[0];
        IR_ADDR:   tdo = addrSr_q[0];
        default:   tdo = bypass_q;
      endcase
    end
  end

  // Scan registers: capture beats shift; tdi enters at the MSB.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bypass_q   <= 1'b0;
      idSr_q     <= '0;
      statusSr_q <= '0;
      valueSr_q  <= '0;
      procSr_q   <= '0;
      addrSr_q   <= '0;
    end else begin
      bypass_q <= tdi;
      case (ir)
        IR_IDCODE: begin
          if (cdr)      idSr_q <= IDCODE;
          else if (sdr) idSr_q <= {tdi, idSr_q[31:1]};
        end
        IR_STATUS: begin
          if (cdr)      statusSr_q <= statusCapture;
          else if (sdr) statusSr_q <= {tdi, statusSr_q[16:1]};
        end
        IR_VALUE: begin
          if (cdr)      valueSr_q <= valueCapture;
          else if (sdr) valueSr_q <= {tdi, valueSr_q[DATA_WIDTH+1:1]};
        end
        IR_RUN: begin
          if (cdr)      procSr_q <= debugProc_q;
          else if (sdr) procSr_q <= {tdi, procSr_q[PROC_WIDTH-1:1]};
        end
        IR_ADDR: begin
          if (cdr)      addrSr_q <= addr_q;
          else if (sdr) addrSr_q <= {tdi, addrSr_q[ADDR_WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

  // FSM state register; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (valueStart)    state_d = BUS;
        else if (runStart) state_d = RUN_START;
      end
      BUS: begin
        if (dbg.dbg_ack || timeoutHit) state_d = IDLE;
      end
      RUN_START: begin
        if (!debug_stopped)  state_d = RUN_STOP;
        else if (timeoutHit) state_d = IDLE;
      end
      RUN_STOP: begin
        if (debug_stopped || timeoutHit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; dbg_req is decoded from state so reset drops it without a clock.
  always_comb begin
    busy        = (state_q != IDLE);
    dbg.dbg_req = (state_q == BUS);
  end

  assign dbg.dbg_wr     = busWr_q;
  assign dbg.dbg_addr   = addr_q;
  assign dbg.dbg_wr_val = busWrVal_q;
  assign debug_seize    = debugSeize_q;
  assign debug_reset    = debugReset_q;
  assign debug_run      = debugRun_q;
  assign debug_proc     = debugProc_q;

  // Control, sticky errors, address, shadow and timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= '0;
      shadow_q     <= '0;
      busWrVal_q   <= '0;
      busWr_q      <= 1'b0;
      autoInc_q    <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
      debugSeize_q <= 1'b1;
      debugReset_q <= 1'b0;
      debugRun_q   <= 1'b0;
      debugProc_q  <= '0;
      timeoutCnt_q <= '0;
    end else begin
      debugRun_q <= 1'b0;
      overrun_q  <= (overrun_q & ~clearErr) | overrunSet;
      timeout_q  <= (timeout_q & ~clearErr) | timeoutEvent;
      if (statusWrite) begin
        debugSeize_q <= ~statusSr_q[0];
        debugReset_q <= statusSr_q[1];
        autoInc_q    <= statusSr_q[3];
      end
      if (isIdle) begin
        if (valueStart) begin
          busWr_q    <= valueSr_q[DATA_WIDTH];
          busWrVal_q <= valueSr_q[DATA_WIDTH-1:0];
        end else if (runStart) begin
          debugRun_q  <= 1'b1;
          debugProc_q <= procSr_q;
        end
        if (addrLoad) addr_q <= addrSr_q;
      end
      if (busDone) begin
        if (!busWr_q) shadow_q <= dbg.dbg_rd_val;
        if (autoInc_q) addr_q <= addr_q + ADDR_WIDTH'(1);
      end
      if (runDone) shadow_q <= debug_val;
      if (isIdle) timeoutCnt_q <= '0;
      else        timeoutCnt_q <= timeoutCnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_jtag_debug_bridge_v2.sv
// Directed bench for jtag_debug_bridge_v2 with a 16-cycle timeout.
module tb_jtag_debug_bridge_v2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  ir;
  logic        tdi, tdo, sdr, cdr, udr;
  logic        debug_stopped, debug_seize, debug_reset, debug_run;
  logic [7:0]  debug_proc;
  logic [15:0] debug_val;

  int checks   = 0;
  int failures = 0;
  int reqCycles;
  logic [63:0] rd;
  logic [7:0]  pat;

  jtag_debug_bridge_v2_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dbg ();

  jtag_debug_bridge_v2 #(
    .DATA_WIDTH(16), .ADDR_WIDTH(16), .PROC_WIDTH(8),
    .IDCODE(32'h53454c49), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .ir(ir), .tdi(tdi), .tdo(tdo),
    .sdr(sdr), .cdr(cdr), .udr(udr),
    .debug_stopped(debug_stopped), .debug_seize(debug_seize),
    .debug_reset(debug_reset), .debug_run(debug_run),
    .debug_proc(debug_proc), .debug_val(debug_val),
    .dbg(dbg.master)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One DR scan: capture, len shifts LSB-first collecting tdo, optional update.
  task automatic applyStimulus(input logic [2:0] irVal, input int len, input logic [63:0] dataIn,
                               input bit doUpdate, output logic [63:0] dataOut);
    dataOut = '0;
    @(negedge clk);
    ir  = irVal;
    cdr = 1'b1;
    @(negedge clk);
    cdr = 1'b0;
    for (int i = 0; i < len; i++) begin
      sdr = 1'b1;
      tdi = dataIn[i];
      #1 dataOut[i] = tdo;
      @(negedge clk);
    end
    sdr = 1'b0;
    if (doUpdate) begin
      udr = 1'b1;
      @(negedge clk);
      udr = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; ir = 3'd0; tdi = 1'b0; sdr = 1'b0; cdr = 1'b0; udr = 1'b0;
    debug_stopped = 1'b1; debug_val = 16'h0;
    dbg.dbg_rd_val = 16'h0; dbg.dbg_ack = 1'b0;
    repeat (2) @(negedge clk);

    // Reset values
    checkOutput("rst_seize", debug_seize, 64'd1);
    checkOutput("rst_dreset", debug_reset, 64'd0);
    checkOutput("rst_run", debug_run, 64'd0);
    checkOutput("rst_req", dbg.dbg_req, 64'd0);
    checkOutput("rst_addr", dbg.dbg_addr, 64'd0);
    checkOutput("rst_proc", debug_proc, 64'd0);
    reset_n = 1'b1;

    // IDCODE shifts out LSB-first
    applyStimulus(3'd0, 32, 64'h0, 1'b0, rd);
    checkOutput("idcode", rd, 64'h53454c49);

    // Bypass: tdo follows tdi one cycle later, with and without sdr
    ir  = 3'd7;
    pat = 8'b1011_0010;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tdi = pat[i];
      sdr = i[0];
      @(negedge clk);
      checkOutput("bypass", tdo, pat[i]);
    end
    sdr = 1'b0;

    // Bus write with auto-increment
    applyStimulus(3'd4, 16, 64'h0010, 1'b1, rd);
    checkOutput("addr_load", dbg.dbg_addr, 64'h0010);
    applyStimulus(3'd1, 17, 64'h1_0009, 1'b1, rd);
    checkOutput("seize_off", debug_seize, 64'd0);
    applyStimulus(3'd2, 18, 64'h1BEEF, 1'b1, rd);
    checkOutput("wr_req", dbg.dbg_req, 64'd1);
    checkOutput("wr_dir", dbg.dbg_wr, 64'd1);
    checkOutput("wr_addr", dbg.dbg_addr, 64'h0010);
    checkOutput("wr_data", dbg.dbg_wr_val, 64'hBEEF);
    repeat (2) @(negedge clk);
    checkOutput("wr_hold", {dbg.dbg_req, dbg.dbg_addr, dbg.dbg_wr_val}, {1'b1, 16'h0010, 16'hBEEF});
    dbg.dbg_ack = 1'b1;
    @(negedge clk);
    dbg.dbg_ack = 1'b0;
    checkOutput("wr_req_drop", dbg.dbg_req, 64'd0);
    checkOutput("wr_autoinc", dbg.dbg_addr, 64'h0011);
    applyStimulus(3'd4, 16, 64'h0, 1'b0, rd);
    checkOutput("addr_capture", rd, 64'h0011);

    // Bus read at 0xFFFF wraps to 0x0000
    applyStimulus(3'd4, 16, 64'hFFFF, 1'b1, rd);
    dbg.dbg_rd_val = 16'h1234;
    applyStimulus(3'd2, 18, 64'h20000, 1'b1, rd);
    checkOutput("rd_req", dbg.dbg_req, 64'd1);
    checkOutput("rd_dir", dbg.dbg_wr, 64'd0);
    dbg.dbg_ack = 1'b1;
    @(negedge clk);
    dbg.dbg_ack = 1'b0;
    checkOutput("rd_wrap", dbg.dbg_addr, 64'h0000);
    applyStimulus(3'd2, 18, 64'h0, 1'b1, rd);
    checkOutput("rd_value", rd, 64'h11234);

    // Ack while idle is ignored
    dbg.dbg_rd_val = 16'h7777;
    dbg.dbg_ack = 1'b1;
    @(negedge clk);
    dbg.dbg_ack = 1'b0;
    checkOutput("idle_ack_addr", dbg.dbg_addr, 64'h0000);
    applyStimulus(3'd2, 18, 64'h0, 1'b1, rd);
    checkOutput("idle_ack_value", rd, 64'h11234);

    // Procedure run
    applyStimulus(3'd3, 8, 64'h5A, 1'b1, rd);
    checkOutput("run_pulse", debug_run, 64'd1);
    checkOutput("run_proc", debug_proc, 64'h5A);
    @(negedge clk);
    checkOutput("run_pulse_end", debug_run, 64'd0);
    debug_stopped = 1'b0;
    @(negedge clk);
    debug_stopped = 1'b1;
    debug_val = 16'hCAFE;
    @(negedge clk);
    applyStimulus(3'd2, 18, 64'h0, 1'b1, rd);
    checkOutput("run_value", rd, 64'h1CAFE);

    // Bus timeout, with an overrunning VALUE update while busy
    applyStimulus(3'd2, 18, 64'h10055, 1'b1, rd);
    reqCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (dbg.dbg_req !== 1'b1) break;
      reqCycles++;
      udr = (i == 3);
      @(negedge clk);
    end
    udr = 1'b0;
    checkOutput("to_req_cycles", reqCycles, 64'd16);
    checkOutput("to_addr_kept", dbg.dbg_addr, 64'h0000);
    applyStimulus(3'd2, 18, 64'h0, 1'b1, rd);
    checkOutput("to_shadow_kept", rd, 64'h1CAFE);
    applyStimulus(3'd1, 17, 64'h0, 1'b1, rd);
    checkOutput("to_status", rd, 64'h18);
    debug_stopped = 1'b0;
    applyStimulus(3'd1, 17, 64'h1_000F, 1'b1, rd);
    checkOutput("dreset_on", debug_reset, 64'd1);
    applyStimulus(3'd1, 17, 64'h0, 1'b1, rd);
    checkOutput("status_cleared", rd, 64'h3);

    // Reset in the middle of a bus transaction
    applyStimulus(3'd2, 18, 64'h10077, 1'b1, rd);
    checkOutput("mid_req", dbg.dbg_req, 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_req", dbg.dbg_req, 64'd0);
    checkOutput("abort_seize", debug_seize, 64'd1);
    checkOutput("abort_dreset", debug_reset, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    debug_stopped = 1'b1;
    applyStimulus(3'd2, 18, 64'h0, 1'b1, rd);
    checkOutput("abort_shadow", rd, 64'h10000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
